// File: rtl/prbs_seq_ctrl_pkg.sv
// Shared definitions for the PRBS9 lane sequencer: FSM encoding and PRBS9 constants.
package prbs_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int         PRBS9_PERIOD = 511;
  localparam logic [8:0] PRBS9_SEED   = 9'h1FF;

endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// Control/status bundle between the PRBS sequencer and its host.
// Optional i_repeat exists only when PRBS_SEQ_CTRL_REPEAT_EN is defined.
interface prbs_seq_ctrl_if #(
  parameter int NB_LEN   = 16,
  parameter int NB_PHASE = 2
);
  logic                i_start;
  logic                i_stop;
  logic [NB_LEN-1:0]   i_len;
  logic [NB_PHASE-1:0] i_os_phase;
`ifdef PRBS_SEQ_CTRL_REPEAT_EN
  logic                i_repeat;
`endif
  logic                o_prbs_en;
  logic                o_prbs_rst;
  logic                o_prbs_step;
  logic                o_busy;
  logic                o_done;
  logic [NB_LEN-1:0]   o_bit_cnt;
  logic                o_period_mark;

`ifdef PRBS_SEQ_CTRL_REPEAT_EN
  modport master (output i_start, i_stop, i_len, i_os_phase, i_repeat,
                  input  o_prbs_en, o_prbs_rst, o_prbs_step, o_busy, o_done, o_bit_cnt, o_period_mark);
  modport slave  (input  i_start, i_stop, i_len, i_os_phase, i_repeat,
                  output o_prbs_en, o_prbs_rst, o_prbs_step, o_busy, o_done, o_bit_cnt, o_period_mark);
`else
  modport master (output i_start, i_stop, i_len, i_os_phase,
                  input  o_prbs_en, o_prbs_rst, o_prbs_step, o_busy, o_done, o_bit_cnt, o_period_mark);
  modport slave  (input  i_start, i_stop, i_len, i_os_phase,
                  output o_prbs_en, o_prbs_rst, o_prbs_step, o_busy, o_done, o_bit_cnt, o_period_mark);
`endif
endinterface

// File: rtl/prbs_seq_ctrl_os_timer.sv
// Oversampling counter and phase compare; o_step is the registered symbol strobe,
// o_step_next is its next-cycle value for logic that must register alongside it.
module prbs_seq_os_timer #(
  parameter int OS_FACTOR = 4,
  parameter int NB_PHASE  = 2
) (
  input  logic                clk,
  input  logic                i_reset_n,
  input  logic                i_run,
  input  logic                i_run_next,
  input  logic [NB_PHASE-1:0] i_phase,
  output logic                o_step_next,
  output logic                o_step
);

  localparam logic [NB_PHASE-1:0] OS_LAST = NB_PHASE'(OS_FACTOR - 1);

  logic [NB_PHASE-1:0] os_cnt_q, os_cnt_d;
  logic                step_q;

  // Counter sits at 0 outside RUN so the first RUN cycle is always phase 0.
  always_comb begin
    os_cnt_d = '0;
    if (i_run) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + NB_PHASE'(1);
    end
  end

  assign o_step_next = i_run_next && (os_cnt_d == i_phase);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      os_cnt_q <= '0;
      step_q   <= 1'b0;
    end else begin
      os_cnt_q <= os_cnt_d;
      step_q   <= o_step_next;
    end
  end

  assign o_step = step_q;

endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS9 I/Q lane sequencer: burst/continuous step strobes, done pulse and period marks.
// Build option PRBS_SEQ_CTRL_REPEAT_EN adds i_repeat (auto-restart after each burst).
//
//   state | meaning
//   IDLE  | generators disabled, waiting for start
//   LOAD  | one cycle: reseed generators, clear counters
//   RUN   | stepping once per symbol at the latched phase
module prbs_seq_ctrl
  import prbs_seq_ctrl_pkg::*;
#(
  parameter int OS_FACTOR   = 4,
  parameter int NB_LEN      = 16,
  parameter int NB_PHASE    = 2,
  parameter int PRBS_PERIOD = PRBS9_PERIOD
) (
  input logic             clk,
  input logic             i_reset_n,
  prbs_seq_ctrl_if.slave  bus
);

  localparam int                  NB_PER    = $clog2(PRBS_PERIOD);
  localparam logic [NB_PHASE-1:0] PHASE_MAX = NB_PHASE'(OS_FACTOR - 1);
  localparam logic [NB_LEN-1:0]   BIT_MAX   = '1;
  localparam logic [NB_PER-1:0]   PER_LAST  = NB_PER'(PRBS_PERIOD - 1);

  state_e              state_q, state_d;
  logic [NB_LEN-1:0]   len_q, len_d;
  logic [NB_PHASE-1:0] phase_q, phase_d;
  logic [NB_LEN-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_PER-1:0]   period_cnt_q, period_cnt_d;
  logic                en_q, rst_q, busy_q, done_q, mark_q;
  logic                done_d, mark_d;
  logic                step_q, step_next, last_step, repeat_req;

  prbs_seq_os_timer #(
    .OS_FACTOR (OS_FACTOR),
    .NB_PHASE  (NB_PHASE)
  ) u_os_timer (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_run       (state_q == ST_RUN),
    .i_run_next  (state_d == ST_RUN),
    .i_phase     (phase_q),
    .o_step_next (step_next),
    .o_step      (step_q)
  );

`ifdef PRBS_SEQ_CTRL_REPEAT_EN
  assign repeat_req = bus.i_repeat;
`else
  assign repeat_req = 1'b0;
`endif

  assign last_step = step_q && (len_q != '0) && (bit_cnt_q == len_q - NB_LEN'(1));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    period_cnt_d = period_cnt_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_stop) begin
          len_d   = bus.i_len;
          phase_d = (bus.i_os_phase > PHASE_MAX) ? PHASE_MAX : bus.i_os_phase;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_cnt_d    = '0;
        period_cnt_d = '0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (step_q) begin
          if (bit_cnt_q != BIT_MAX) bit_cnt_d = bit_cnt_q + NB_LEN'(1);
          period_cnt_d = (period_cnt_q == PER_LAST) ? '0 : period_cnt_q + NB_PER'(1);
        end
        // Stop wins over completion, even when it lands on the final step.
        if (bus.i_stop) begin
          state_d = ST_IDLE;
        end else if (last_step) begin
          done_d  = 1'b1;
          state_d = repeat_req ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Steps are at least two clocks apart, so period_cnt_d is the count the next step sees.
  assign mark_d = step_next && (period_cnt_d == PER_LAST);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      period_cnt_q <= '0;
      en_q         <= 1'b0;
      rst_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mark_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      period_cnt_q <= period_cnt_d;
      en_q         <= (state_d != ST_IDLE);
      rst_q        <= (state_d == ST_LOAD);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= done_d;
      mark_q       <= mark_d;
    end
  end

  assign bus.o_prbs_en     = en_q;
  assign bus.o_prbs_rst    = rst_q;
  assign bus.o_prbs_step   = step_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_bit_cnt     = bit_cnt_q;
  assign bus.o_period_mark = mark_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl (OS_FACTOR=4 main instance, OS_FACTOR=3 clamp instance).
module tb_prbs_seq_ctrl;
  import prbs_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prbs_seq_ctrl_if #(.NB_LEN(16), .NB_PHASE(2)) bus  ();
  prbs_seq_ctrl_if #(.NB_LEN(16), .NB_PHASE(2)) bus3 ();

  prbs_seq_ctrl #(.OS_FACTOR(4), .NB_LEN(16), .NB_PHASE(2), .PRBS_PERIOD(511)) dut (
    .clk(clk), .i_reset_n(rst_n), .bus(bus.slave));
  prbs_seq_ctrl #(.OS_FACTOR(3), .NB_LEN(16), .NB_PHASE(2), .PRBS_PERIOD(511)) dut3 (
    .clk(clk), .i_reset_n(rst_n), .bus(bus3.slave));

  int vectors = 0;
  int miscompares = 0;

  // Lane generator model (x^9 + x^5 + 1) driven by the DUT control outputs
  logic [8:0] lane_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                lane_q <= PRBS9_SEED;
    else if (bus.o_prbs_rst)                   lane_q <= PRBS9_SEED;
    else if (bus.o_prbs_en && bus.o_prbs_step) lane_q <= {lane_q[7:0], lane_q[8] ^ lane_q[4]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_basic(input string pfx);
    bus.i_len = 16'd10; bus.i_os_phase = 2'd1; bus.i_start = 1'b1;   // cycle 0
    tick();                                                          // cycle 1
    bus.i_start = 1'b0;
    chk({pfx, "_load"}, 32'({bus.o_prbs_rst, bus.o_prbs_en, bus.o_busy, bus.o_prbs_step}), 32'hE);
    for (int c = 2; c <= 41; c++) begin
      bus.i_start = (c == 11);  // stray start while running
      tick();
      chk({pfx, "_step"}, 32'(bus.o_prbs_step), 32'(c >= 3 && c <= 39 && (c - 3) % 4 == 0));
      chk({pfx, "_done"}, 32'(bus.o_done), 32'(c == 40));
      chk({pfx, "_busy"}, 32'(bus.o_busy), 32'(c <= 39));
      chk({pfx, "_rst"},  32'(bus.o_prbs_rst), 32'd0);
    end
    bus.i_start = 1'b0;
    chk({pfx, "_bitcnt"}, 32'(bus.o_bit_cnt), 32'd10);
    chk({pfx, "_lane"},   32'(lane_q), 32'h01E);
  endtask

  initial begin
    int steps, first_step, marks, mark1, mark2, mark_no_step, done_seen;
    int s1, s2, s3, d3;
    rst_n = 1'b0;
    bus.i_start = 0;  bus.i_stop = 0;  bus.i_len = '0;  bus.i_os_phase = '0;
    bus3.i_start = 0; bus3.i_stop = 0; bus3.i_len = '0; bus3.i_os_phase = '0;
`ifdef PRBS_SEQ_CTRL_REPEAT_EN
    bus.i_repeat = 1'b0; bus3.i_repeat = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_flags", 32'({bus.o_prbs_en, bus.o_prbs_rst, bus.o_prbs_step, bus.o_busy,
                           bus.o_done, bus.o_period_mark}), 32'd0);
    chk("reset_bitcnt", 32'(bus.o_bit_cnt), 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) tick();

    // Basic burst with a stray start during RUN
    run_basic("basic");

    // Start and stop together in IDLE
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    tick();
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    chk("startstop_busy", 32'(bus.o_busy), 32'd0);
    chk("startstop_rst",  32'(bus.o_prbs_rst), 32'd0);
    tick();
    chk("startstop_busy2", 32'(bus.o_busy), 32'd0);

    // Abort after step 20 (phase 2: steps at cycles 4, 8, ...)
    bus.i_len = 16'd100; bus.i_os_phase = 2'd2; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    steps = 0; first_step = -1;
    for (int c = 2; c < 300 && steps < 20; c++) begin
      tick();
      if (bus.o_prbs_step) begin
        steps++;
        if (steps == 1) first_step = c;
      end
    end
    chk("abort_first_step", 32'(first_step), 32'd4);
    chk("abort_steps", 32'(steps), 32'd20);
    tick();
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    chk("abort_flags", 32'({bus.o_busy, bus.o_prbs_en, bus.o_done}), 32'd0);
    chk("abort_bitcnt", 32'(bus.o_bit_cnt), 32'd20);
    done_seen = 0;
    repeat (6) begin tick(); if (bus.o_done) done_seen = 1; end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_bitcnt_hold", 32'(bus.o_bit_cnt), 32'd20);

    // Continuous mode: 1100 steps, stop coincident with the last one
    bus.i_len = 16'd0; bus.i_os_phase = 2'd0; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    steps = 0; marks = 0; mark1 = -1; mark2 = -1; mark_no_step = 0; done_seen = 0;
    for (int c = 2; c < 6000 && steps < 1100; c++) begin
      tick();
      if (bus.o_prbs_step) steps++;
      if (bus.o_period_mark) begin
        marks++;
        if (!bus.o_prbs_step) mark_no_step++;
        if (marks == 1) mark1 = steps;
        if (marks == 2) mark2 = steps;
      end
      if (bus.o_done) done_seen = 1;
    end
    chk("cont_steps", 32'(steps), 32'd1100);
    chk("cont_marks", 32'(marks), 32'd2);
    chk("cont_mark1", 32'(mark1), 32'd511);
    chk("cont_mark2", 32'(mark2), 32'd1022);
    chk("cont_mark_on_step", 32'(mark_no_step), 32'd0);
    chk("cont_no_done", 32'(done_seen), 32'd0);
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    chk("cont_stop_flags", 32'({bus.o_busy, bus.o_prbs_en, bus.o_done}), 32'd0);
    chk("cont_stop_bitcnt", 32'(bus.o_bit_cnt), 32'd1100);

    // Phase clamp on the OS_FACTOR=3 instance: phase 3 -> 2
    bus3.i_len = 16'd3; bus3.i_os_phase = 2'd3; bus3.i_start = 1'b1;
    tick();
    bus3.i_start = 1'b0;
    chk("clamp_load", 32'(bus3.o_prbs_rst), 32'd1);
    s1 = -1; s2 = -1; s3 = -1; d3 = -1; steps = 0;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (bus3.o_prbs_step) begin
        steps++;
        if (steps == 1) s1 = c;
        if (steps == 2) s2 = c;
        if (steps == 3) s3 = c;
      end
      if (bus3.o_done && d3 < 0) d3 = c;
    end
    chk("clamp_step1", 32'(s1), 32'd4);
    chk("clamp_step2", 32'(s2), 32'd7);
    chk("clamp_step3", 32'(s3), 32'd10);
    chk("clamp_done", 32'(d3), 32'd11);
    chk("clamp_bitcnt", 32'(bus3.o_bit_cnt), 32'd3);

    // Asynchronous reset mid-burst, then the basic timing again
    bus.i_len = 16'd10; bus.i_os_phase = 2'd1; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (14) tick();                                  // cycle 15
    chk("midburst_bitcnt", 32'(bus.o_bit_cnt), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_flags", 32'({bus.o_prbs_en, bus.o_prbs_rst, bus.o_prbs_step, bus.o_busy,
                            bus.o_done, bus.o_period_mark}), 32'd0);
    chk("areset_bitcnt", 32'(bus.o_bit_cnt), 32'd0);
    #8 rst_n = 1'b1;
    tick();
    run_basic("rerun");

`ifdef PRBS_SEQ_CTRL_REPEAT_EN
    // Repeat: len 5, phase 3 -> LOAD/done every 21 cycles (cycles 22, 43)
    begin
      int dn1, dn2, ndone;
      bus.i_repeat = 1'b1; bus.i_len = 16'd5; bus.i_os_phase = 2'd3; bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      dn1 = -1; dn2 = -1; ndone = 0;
      for (int c = 2; c <= 46; c++) begin
        tick();
        if (bus.o_done) begin
          ndone++;
          if (ndone == 1) dn1 = c;
          if (ndone == 2) dn2 = c;
        end
        if (c == 22) begin
          chk("rep_rst1", 32'(bus.o_prbs_rst), 32'd1);
          chk("rep_lane_end", 32'(lane_q), 32'h1E0);
          chk("rep_busy", 32'(bus.o_busy), 32'd1);
        end
        if (c == 23) chk("rep_lane_seed", 32'(lane_q), 32'(PRBS9_SEED));
        if (c == 43) chk("rep_rst2", 32'(bus.o_prbs_rst), 32'd1);
      end
      chk("rep_done1", 32'(dn1), 32'd22);
      chk("rep_done2", 32'(dn2), 32'd43);
      bus.i_stop = 1'b1;
      tick();
      bus.i_stop = 1'b0; bus.i_repeat = 1'b0;
      chk("rep_stop_busy", 32'(bus.o_busy), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
